hazard_fwd_ctrl: RTL and testbench
==================================

Name: hazard_fwd_ctrl

Overview:
Hazard and forwarding controller for the pipelined CPU's ID stage. It generates the select codes for the two 32-bit ALU-operand forwarding muxes and detects load-use hazards. It also sequences the multi-cycle multiply/divide unit with a busy counter, stalling PC and IF/ID as required. It holds a saturating stall-cycle counter for performance debug.

Parameters:
MD_CYCLES, 4, cycles the mult/div unit is busy per operation (legal range 2..255)
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
ex_wreg  in  1  EX instruction writes the register file
ex_m2reg  in  1  EX instruction is a load
ex_rd  in  5  EX destination register
mem_wreg  in  1  MEM instruction writes the register file
mem_m2reg  in  1  MEM instruction is a load
mem_rd  in  5  MEM destination register
id_md_start  in  1  ID instruction is mult/div
id_hilo_rd  in  1  ID instruction is mfhi/mflo
fwda  out  2  operand-A mux select
fwdb  out  2  operand-B mux select
wpcir  out  1  PC and IF/ID write enable (0 = stall)
bubble  out  1  force a NOP into ID/EX
md_busy  out  1  mult/div operation in progress
md_done  out  1  final busy cycle; HI/LO valid at next edge
stall_cnt  out  CNT_W  saturating count of cycles with wpcir=0

Behaviour:
- Forward encoding: 00 = register file, 01 = EX ALU result, 10 = MEM ALU result, 11 = MEM load data.
- fwda is combinational. Priority order:
  - EX match (ex_wreg, ex_rd!=0, ex_rd==id_rs) gives 01.
  - Otherwise MEM match (mem_wreg, mem_rd!=0, mem_rd==id_rs) gives 10 if !mem_m2reg, or 11 if mem_m2reg.
  - Otherwise 00.
  - fwdb follows the same rules using id_rt.
  - id_use_rs and id_use_rt do not gate the fwd codes.
- Register $0 never forwards, including when a write to rd=0 is in flight.
- Load-use hazard (lu) is asserted when all of the following hold:
  - ex_wreg && ex_m2reg && ex_rd!=0;
  - and either (id_use_rs && ex_rd==id_rs) or (id_use_rt && ex_rd==id_rt).
- md stall (ms) = md_busy && !md_done && (id_md_start || id_hilo_rd).
- Outputs: wpcir = !(lu || ms); bubble = lu || ms. Both are combinational.
- MD FSM states are IDLE and BUSY, with a count register cnt of 8 bits.
  - IDLE: md_busy=0. If id_md_start && !lu, then cnt <= MD_CYCLES-1 and the FSM moves to BUSY.
  - BUSY: md_busy=1 and cnt decrements each cycle. md_done = (cnt==0), combinational.
  - BUSY with cnt==0: if id_md_start && !lu, reload cnt <= MD_CYCLES-1 and stay in BUSY (back-to-back accept). Otherwise go to IDLE.
  - id_md_start while BUSY with cnt!=0 is not accepted. It produces ms, and the instruction is held in ID.
- Latency: when a start is accepted at edge T, md_busy is high for exactly MD_CYCLES cycles after T, and md_done is high in the last of those cycles.
- A pending lu blocks md acceptance in both states, since the instruction is bubbled.
- stall_cnt increments on every rising edge where wpcir==0 and saturates at all-ones. It is never cleared except by rst.
- Reset values (async, immediate): state IDLE, cnt=0, stall_cnt=0, md_busy=0, md_done=0.
  - Combinational outputs follow their inputs during reset, with ms forced to 0.
  - Reset mid-operation abandons the operation; no md_done pulse is produced.

Test Plan:
1. ex_wreg=1, ex_rd=5, mem_wreg=1, mem_rd=5, id_rs=5 -> fwda=01 (EX wins); then drop ex_wreg -> fwda=10; set mem_m2reg=1 -> fwda=11.
2. ex_wreg=1, ex_rd=0, id_rs=0, id_use_rs=1, ex_m2reg=1 -> fwda=00, wpcir=1, bubble=0.
3. Load in EX, ex_rd=8, id_rt=8, id_use_rt=1 -> wpcir=0, bubble=1 for 1 cycle; stall_cnt 0->1; same with id_use_rt=0 -> no stall.
4. MD_CYCLES=4, id_md_start pulse at edge T -> md_busy high cycles T+1..T+4, md_done only in T+4; id_hilo_rd=1 held -> wpcir=0 for 3 cycles, 1 in the md_done cycle.
5. id_md_start held high continuously -> accepted at T and again at T+4 (back-to-back), md_busy never drops, one md_done per 4 cycles.
6. rst asserted in 2nd BUSY cycle -> md_busy=0, stall_cnt=0 immediately, no md_done; also force 2^CNT_W+3 stall cycles -> stall_cnt stays 0xFFFF.

Source files
------------

// File: rtl/hazard_fwd_ctrl.sv
// ID-stage hazard/forwarding control: combinational forward selects and stalls (0-cycle),
// plus a registered mult/div busy sequencer and saturating stall counter; holds PC/IF-ID via wpcir.
module hazard_fwd_ctrl #(
  parameter int MD_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_wreg,
  input  logic             ex_m2reg,
  input  logic [4:0]       ex_rd,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic [4:0]       mem_rd,
  input  logic             id_md_start,
  input  logic             id_hilo_rd,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             wpcir,
  output logic             bubble,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_t;

  md_state_t  state;
  logic [7:0] cnt;

  logic ex_ok, mem_ok;
  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic lu, ms, stall, md_accept;

  // Writes to $0 are discarded by the register file, so they must never forward.
  assign ex_ok     = ex_wreg && (ex_rd != 5'd0);
  assign mem_ok    = mem_wreg && (mem_rd != 5'd0);
  assign ex_hit_a  = ex_ok && (ex_rd == id_rs);
  assign ex_hit_b  = ex_ok && (ex_rd == id_rt);
  assign mem_hit_a = mem_ok && (mem_rd == id_rs);
  assign mem_hit_b = mem_ok && (mem_rd == id_rt);

  assign fwda = ex_hit_a  ? 2'b01 :
                mem_hit_a ? (mem_m2reg ? 2'b11 : 2'b10) : 2'b00;
  assign fwdb = ex_hit_b  ? 2'b01 :
                mem_hit_b ? (mem_m2reg ? 2'b11 : 2'b10) : 2'b00;

  assign lu = ex_ok && ex_m2reg &&
              ((id_use_rs && ex_hit_a) || (id_use_rt && ex_hit_b));

  assign md_busy = (state == BUSY);
  assign md_done = md_busy && (cnt == 8'd0);

  assign ms     = !rst && md_busy && !md_done && (id_md_start || id_hilo_rd);
  assign stall  = lu || ms;
  assign wpcir  = !stall;
  assign bubble = stall;

  // A bubbled load-use instruction is not really in ID yet, so it cannot start the unit.
  assign md_accept = id_md_start && !lu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (md_accept) begin
            cnt   <= 8'(MD_CYCLES - 1);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (md_accept) begin
            cnt <= 8'(MD_CYCLES - 1);
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!wpcir && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed plan scenarios plus random traffic, checked against a remaining-cycles model.
module tb_hazard_fwd_ctrl;

  localparam int MD_CYCLES = 4;
  localparam int CNT_W     = 16;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs, id_rt, ex_rd, mem_rd;
  logic             id_use_rs, id_use_rt, ex_wreg, ex_m2reg, mem_wreg, mem_m2reg;
  logic             id_md_start, id_hilo_rd;
  logic [1:0]       fwda, fwdb;
  logic             wpcir, bubble, md_busy, md_done;
  logic [CNT_W-1:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int rem      = 0;   // model: busy cycles still to come, 0 = idle
  int sc       = 0;   // model: stall counter

  hazard_fwd_ctrl #(.MD_CYCLES(MD_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rd(ex_rd),
    .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rd(mem_rd),
    .id_md_start(id_md_start), .id_hilo_rd(id_hilo_rd),
    .fwda(fwda), .fwdb(fwdb), .wpcir(wpcir), .bubble(bubble),
    .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int m_fwd(input logic [4:0] r);
    if (ex_wreg && ex_rd != 0 && ex_rd == r) return 1;
    if (mem_wreg && mem_rd != 0 && mem_rd == r) return mem_m2reg ? 3 : 2;
    return 0;
  endfunction

  function automatic bit m_lu();
    return ex_wreg && ex_m2reg && ex_rd != 0 &&
           ((id_use_rs && ex_rd == id_rs) || (id_use_rt && ex_rd == id_rt));
  endfunction

  function automatic bit m_stall();
    return m_lu() || (rem > 1 && (id_md_start || id_hilo_rd));
  endfunction

  // Checks all outputs mid-cycle, then advances the model across the rising edge.
  task automatic cycle(input bit do_chk);
    bit st, lu;
    @(negedge clk);
    st = m_stall();
    lu = m_lu();
    if (do_chk) begin
      chk("fwda", 32'(fwda), 32'(m_fwd(id_rs)));
      chk("fwdb", 32'(fwdb), 32'(m_fwd(id_rt)));
      chk("wpcir", 32'(wpcir), 32'(!st));
      chk("bubble", 32'(bubble), 32'(st));
      chk("md_busy", 32'(md_busy), 32'(rem > 0));
      chk("md_done", 32'(md_done), 32'(rem == 1));
      chk("stall_cnt", 32'(stall_cnt), 32'(sc));
    end
    @(posedge clk);
    if (st && sc < CNT_MAX) sc++;
    if (id_md_start && !lu && rem <= 1) rem = MD_CYCLES;
    else if (rem > 0) rem--;
    #1;
  endtask

  task automatic clr_inputs();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    ex_wreg = 0; ex_m2reg = 0; ex_rd = 0;
    mem_wreg = 0; mem_m2reg = 0; mem_rd = 0;
    id_md_start = 0; id_hilo_rd = 0;
  endtask

  initial begin
    int dones, drops;
    clr_inputs();
    rst = 1'b1;
    #1;
    chk("rst_busy", 32'(md_busy), 0);
    chk("rst_done", 32'(md_done), 0);
    chk("rst_cnt", 32'(stall_cnt), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cycle(1);

    // 1: EX beats MEM, then MEM ALU, then MEM load
    ex_wreg = 1; ex_rd = 5; mem_wreg = 1; mem_rd = 5; id_rs = 5; id_rt = 6;
    #1 chk("p1_ex", 32'(fwda), 1);
    chk("p1_rt", 32'(fwdb), 0);
    ex_wreg = 0;
    #1 chk("p1_mem", 32'(fwda), 2);
    mem_m2reg = 1;
    #1 chk("p1_ld", 32'(fwda), 3);
    cycle(1);

    // 2: load to $0 neither forwards nor stalls
    clr_inputs();
    ex_wreg = 1; ex_m2reg = 1; ex_rd = 0; id_rs = 0; id_use_rs = 1;
    #1 chk("p2_fwda", 32'(fwda), 0);
    chk("p2_wpcir", 32'(wpcir), 1);
    chk("p2_bubble", 32'(bubble), 0);
    cycle(1);

    // 3: load-use on rt, then same without the rt read
    clr_inputs();
    ex_wreg = 1; ex_m2reg = 1; ex_rd = 8; id_rt = 8; id_use_rt = 1;
    #1 chk("p3_wpcir", 32'(wpcir), 0);
    chk("p3_bubble", 32'(bubble), 1);
    cycle(1);
    chk("p3_cnt", 32'(stall_cnt), 1);
    id_use_rt = 0;
    #1 chk("p3_nouse", 32'(wpcir), 1);
    cycle(1);
    chk("p3_cnt2", 32'(stall_cnt), 1);

    // 4: single op, mfhi waiting behind it
    clr_inputs();
    id_md_start = 1;
    cycle(1);
    id_md_start = 0; id_hilo_rd = 1;
    for (int k = 1; k <= MD_CYCLES; k++) begin
      chk("p4_busy", 32'(md_busy), 1);
      chk("p4_done", 32'(md_done), 32'(k == MD_CYCLES));
      chk("p4_wpcir", 32'(wpcir), 32'(k == MD_CYCLES));
      cycle(1);
    end
    chk("p4_idle", 32'(md_busy), 0);
    cycle(1);

    // 5: start held high -> back-to-back operations
    clr_inputs();
    id_md_start = 1;
    cycle(1);
    dones = 0; drops = 0;
    for (int k = 0; k < 3 * MD_CYCLES; k++) begin
      if (md_done) dones++;
      if (!md_busy) drops++;
      cycle(1);
    end
    chk("p5_dones", 32'(dones), 3);
    chk("p5_drops", 32'(drops), 0);
    id_md_start = 0;
    repeat (MD_CYCLES) cycle(1);

    // 6: reset in the 2nd busy cycle, then counter saturation
    id_md_start = 1;
    cycle(1);
    id_md_start = 0;
    cycle(1);
    rst = 1'b1; id_rs = 9; ex_wreg = 1; ex_rd = 9; id_hilo_rd = 1;
    #1 chk("p6_busy", 32'(md_busy), 0);
    chk("p6_done", 32'(md_done), 0);
    chk("p6_cnt", 32'(stall_cnt), 0);
    chk("p6_fwda", 32'(fwda), 1);
    chk("p6_wpcir", 32'(wpcir), 1);
    rem = 0; sc = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    clr_inputs();
    repeat (6) cycle(1);
    ex_wreg = 1; ex_m2reg = 1; ex_rd = 3; id_rs = 3; id_use_rs = 1;
    repeat (CNT_MAX + 4) cycle(0);
    chk("p6_sat", 32'(stall_cnt), 32'(CNT_MAX));
    cycle(1);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      id_rs = 5'($urandom_range(0, 3));  id_rt = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));  mem_rd = 5'($urandom_range(0, 3));
      id_use_rs = 1'($urandom);  id_use_rt = 1'($urandom);
      ex_wreg = 1'($urandom);    ex_m2reg = 1'($urandom);
      mem_wreg = 1'($urandom);   mem_m2reg = 1'($urandom);
      id_md_start = ($urandom_range(0, 3) == 0);
      id_hilo_rd  = ($urandom_range(0, 3) == 0);
      cycle(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
